sram_like_bridge_wb: RTL

//  Generalised SRAM-to-SRAM-like bridge between the datapath memory port and the AXI-side SRAM-like bus.
//  - Adds an optional posted-write buffer, so stores retire without waiting for the bus.
//  - Adds a read-only mode for the instruction side.
//  - One instance serves the instruction port and one serves the data port.
//  - Both instances share longest_stall, so a completed access is held while the other side stalls.

---
 rtl/sram_like_pkg.sv | 36 +++
 rtl/sram_like_bridge_wb_wbuf_fifo.sv | 52 +++++
 rtl/sram_like_bridge_wb.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sram_like_pkg.sv
// Shared definitions for the SRAM-like bridges: transfer sizes, bus FSM
// encoding and the byte-strobe decode used to derive size and low address bits.
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } bus_state_t;

    // Returns {size, addr_lo}; illegal patterns fall back to a word at offset 0.
    function automatic logic [3:0] wen_decode(input logic [3:0] wen);
        logic [3:0] res;
        case (wen)
            4'b0001: res = {SIZE_BYTE, 2'd0};
            4'b0010: res = {SIZE_BYTE, 2'd1};
            4'b0100: res = {SIZE_BYTE, 2'd2};
            4'b1000: res = {SIZE_BYTE, 2'd3};
            4'b0011: res = {SIZE_HALF, 2'd0};
            4'b1100: res = {SIZE_HALF, 2'd2};
            4'b1111: res = {SIZE_WORD, 2'd0};
            default: res = {SIZE_WORD, 2'd0};
        endcase
        return res;
    endfunction

    function automatic logic wen_legal(input logic [3:0] wen);
        return wen inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                           4'b0011, 4'b1100, 4'b1111};
    endfunction

endpackage

// File: rtl/sram_like_bridge_wb_wbuf_fifo.sv
// Posted-write FIFO for the bridge; full/empty come from the registered count,
// so a pop frees space only from the following cycle.
module wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sram_like_bridge_wb.sv
// Datapath memory port to SRAM-like bus bridge with an optional posted-write
// buffer; one outstanding bus transfer, buffered stores drain before loads.
module sram_like_bridge_wb
    import sram_like_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WBUF_DEPTH = 4,
    parameter int READ_ONLY  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [1:0]        cpu_rsize,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              longest_stall,
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [31:0]       rdata
);

    localparam logic HAS_BUF = (WBUF_DEPTH > 0) && (READ_ONLY == 0);
    localparam int   ENTRY_W = ADDR_W + 2 + 32;

    bus_state_t        state_q, state_d;
    logic              done_q, done_d;
    logic              cur_cpu_q, cur_cpu_d;
    logic              req_d, wr_d;
    logic [1:0]        size_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic [31:0]       cpu_rdata_d;

    logic              is_store, is_load, cpu_direct;
    logic [3:0]        st_dec;
    logic [ADDR_W-1:0] st_addr;
    logic              buf_push, buf_pop, buf_full, buf_empty;
    logic [ENTRY_W-1:0] push_data, buf_head;

    assign is_store   = (READ_ONLY == 0) && (cpu_wen != 4'b0000);
    assign is_load    = ~is_store;
    assign st_dec     = wen_decode(cpu_wen);
    assign st_addr    = {cpu_addr[ADDR_W-1:2], st_dec[1:0]};
    assign push_data  = {st_addr, st_dec[3:2], cpu_wdata};
    // Loads, and stores when there is no buffer, go straight to the bus.
    assign cpu_direct = cpu_en & ~done_q & (is_load | (is_store & ~HAS_BUF));
    assign cpu_stall  = cpu_en & ~done_q & (is_load | (is_store & buf_full));

    generate
        if (HAS_BUF) begin : g_wbuf
            wbuf_fifo #(
                .DEPTH(WBUF_DEPTH),
                .WIDTH(ENTRY_W)
            ) u_wbuf (
                .clk      (clk),
                .rst      (rst),
                .push     (buf_push),
                .push_data(push_data),
                .pop      (buf_pop),
                .full     (buf_full),
                .empty    (buf_empty),
                .head     (buf_head)
            );
        end else begin : g_nobuf
            assign buf_full  = (READ_ONLY == 0);
            assign buf_empty = 1'b1;
            assign buf_head  = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            cur_cpu_q <= 1'b0;
            req       <= 1'b0;
            wr        <= 1'b0;
            size      <= SIZE_BYTE;
            addr      <= '0;
            wdata     <= '0;
            cpu_rdata <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            cur_cpu_q <= cur_cpu_d;
            req       <= req_d;
            wr        <= wr_d;
            size      <= size_d;
            addr      <= addr_d;
            wdata     <= wdata_d;
            cpu_rdata <= cpu_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (~buf_empty | cpu_direct) state_d = ST_ADDR;
            ST_ADDR: if (addr_ok) state_d = ST_DATA;
            ST_DATA: if (data_ok) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A finished access stays done while the pipeline is stalled, so it is
    // never re-issued or re-pushed before the datapath moves on.
    always_comb begin
        req_d       = req;
        wr_d        = wr;
        size_d      = size;
        addr_d      = addr;
        wdata_d     = wdata;
        cur_cpu_d   = cur_cpu_q;
        cpu_rdata_d = cpu_rdata;
        done_d      = done_q & longest_stall;
        buf_push    = 1'b0;
        buf_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (~buf_empty) begin
                    req_d     = 1'b1;
                    wr_d      = 1'b1;
                    addr_d    = buf_head[ENTRY_W-1 -: ADDR_W];
                    size_d    = buf_head[33:32];
                    wdata_d   = buf_head[31:0];
                    cur_cpu_d = 1'b0;
                end else if (cpu_direct) begin
                    req_d     = 1'b1;
                    wr_d      = is_store;
                    addr_d    = is_store ? st_addr : cpu_addr;
                    size_d    = is_store ? st_dec[3:2] : cpu_rsize;
                    wdata_d   = cpu_wdata;
                    cur_cpu_d = 1'b1;
                end
            end
            ST_ADDR: begin
                if (addr_ok)
                    req_d = 1'b0;
            end
            ST_DATA: begin
                if (data_ok) begin
                    if (cur_cpu_q) begin
                        done_d = 1'b1;
                        if (~wr)
                            cpu_rdata_d = rdata;
                    end else begin
                        buf_pop = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (HAS_BUF && cpu_en && is_store && !buf_full && !done_q) begin
            buf_push = 1'b1;
            done_d   = longest_stall;
        end
    end

    a_data_ok_only_in_data: assert property (@(posedge clk) disable iff (rst)
        data_ok |-> (state_q == ST_DATA));

    a_legal_strobe: assert property (@(posedge clk) disable iff (rst)
        (cpu_en && is_store) |-> wen_legal(cpu_wen));

endmodule
